// File: rtl/wb_cmd_master.sv
// Wishbone command master: queues read/write commands in a circular buffer and
// runs them one at a time on a classic Wishbone bus, returning a response per command.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]            rsp_sts_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_ERR = 2'b01;
  localparam logic [1:0] STS_TMO = 2'b10;

  logic                  q_we_r  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_adr_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_dat_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic [1:0]            state_r;
  logic [TW-1:0]         tmo_r;
  logic                  cyc_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_dat_r;
  logic [1:0]            rsp_sts_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Queue status and handshake qualifiers, all derived from registered state.
  always_comb begin
    full_s  = (count_r == FULL_COUNT);
    empty_s = (count_r == {CW{1'b0}});
    push_s  = cmd_valid_i && !full_s && !rst_i;
    pop_s   = (state_r == ST_IDLE) && !empty_s && !rsp_valid_r;
  end

  // Command storage; read commands keep zero write data so dat_o stays 0 on reads.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      q_we_r[wr_ptr_r]  <= cmd_we_i;
      q_adr_r[wr_ptr_r] <= cmd_adr_i;
      q_dat_r[wr_ptr_r] <= cmd_we_i ? cmd_dat_i : {DATA_WIDTH{1'b0}};
    end
  end

  // Circular-buffer pointers (depth is a power of two, so they wrap naturally) and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transaction FSM: IDLE pops a command, BUS waits for ack/err/timeout, RESP holds the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      tmo_r       <= {TW{1'b0}};
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= {ADDR_WIDTH{1'b0}};
      dat_r       <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= {DATA_WIDTH{1'b0}};
      rsp_sts_r   <= STS_OK;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            cyc_r   <= 1'b1;
            we_r    <= q_we_r[rd_ptr_r];
            adr_r   <= q_adr_r[rd_ptr_r];
            dat_r   <= q_dat_r[rd_ptr_r];
            tmo_r   <= {TW{1'b0}};
            state_r <= ST_BUS;
          end
        end
        ST_BUS: begin
          // err takes priority over a simultaneous ack.
          if (err_i || ack_i) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= {ADDR_WIDTH{1'b0}};
            dat_r       <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b1;
            rsp_sts_r   <= err_i ? STS_ERR : STS_OK;
            rsp_dat_r   <= (err_i || we_r) ? {DATA_WIDTH{1'b0}} : dat_i;
            state_r     <= ST_RESP;
          end else if (tmo_r == TMO_LAST) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= {ADDR_WIDTH{1'b0}};
            dat_r       <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b1;
            rsp_sts_r   <= STS_TMO;
            rsp_dat_r   <= {DATA_WIDTH{1'b0}};
            state_r     <= ST_RESP;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cyc_r       <= 1'b0;
          we_r        <= 1'b0;
          adr_r       <= {ADDR_WIDTH{1'b0}};
          dat_r       <= {DATA_WIDTH{1'b0}};
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = !full_s;
  assign cyc_o       = cyc_r;
  assign stb_o       = cyc_r;
  assign we_o        = we_r;
  assign adr_o       = adr_r;
  assign dat_o       = dat_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_dat_o   = rsp_dat_r;
  assign rsp_sts_o   = rsp_sts_r;
  assign busy_o      = !empty_s || (state_r != ST_IDLE) || rsp_valid_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized scoreboard bench for wb_cmd_master: a slave model with per-command
// behaviour plans, and an expected-response queue filled when each command is issued.
module tb_wb_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int DEPTH = 4;
  localparam int TMO = 8;

  localparam logic [1:0] K_ACK  = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_BOTH = 2'd2;
  localparam logic [1:0] K_NONE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr, adr_o;
  logic [DW-1:0] cmd_dat, rsp_dat, dat_o, dat_i;
  logic          rsp_valid, rsp_ready, cyc_o, stb_o, we_o, ack, err, busy;
  logic [1:0]    rsp_sts;

  wb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_sts_o(rsp_sts),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack), .err_i(err), .dat_i(dat_i), .busy_o(busy)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [1:0]    kind;
    logic [7:0]    delay;
    logic [DW-1:0] rdata;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [1:0]    sts;
  } rsp_t;

  cmd_t bus_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit timed_out(input cmd_t c);
    return (c.kind == K_NONE) || (int'(c.delay) >= TMO);
  endfunction

  // Reference response: timeout beats everything, err (alone or with ack) beats ack.
  function automatic rsp_t model_rsp(input cmd_t c);
    rsp_t r;
    if (timed_out(c)) begin
      r.sts = 2'b10; r.dat = '0;
    end else if (c.kind != K_ACK) begin
      r.sts = 2'b01; r.dat = '0;
    end else begin
      r.sts = 2'b00; r.dat = c.we ? '0 : c.rdata;
    end
    return r;
  endfunction

  function automatic int model_len(input cmd_t c);
    return timed_out(c) ? TMO : int'(c.delay) + 1;
  endfunction

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic [1:0] kind, input int delay, input logic [DW-1:0] rdata);
    cmd_t c;
    c.we = we; c.adr = adr; c.dat = dat; c.kind = kind; c.delay = 8'(delay); c.rdata = rdata;
    return c;
  endfunction

  // Slave model and bus-side checks
  cmd_t cur;
  bit   have_cur = 1'b0;
  bit   cyc_prev = 1'b0;
  int   k = 0, len = 0, gap = 100;

  initial begin
    ack = 1'b0; err = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc_prev = 1'b0; gap = 100; have_cur = 1'b0; ack = 1'b0; err = 1'b0;
      end else begin
        check("cyc_eq_stb", stb_o, cyc_o);
        check("no_bus_during_rsp", rsp_valid & cyc_o, 1'b0);
        if (cyc_o && !cyc_prev) begin
          check("bus_gap_ge2", gap >= 2, 1'b1);
          k = 0; len = 0;
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 1'b1, 1'b0);
            have_cur = 1'b0;
          end else begin
            cur = bus_q.pop_front();
            have_cur = 1'b1;
          end
        end else if (cyc_o) begin
          k++;
        end
        if (cyc_o) begin
          len++;
          if (have_cur) begin
            check("bus_we", we_o, cur.we);
            check("bus_adr", adr_o, cur.adr);
            check("bus_dat", dat_o, cur.we ? cur.dat : 16'h0000);
            ack   = ((cur.kind == K_ACK) || (cur.kind == K_BOTH)) && (k >= int'(cur.delay));
            err   = ((cur.kind == K_ERR) || (cur.kind == K_BOTH)) && (k >= int'(cur.delay));
            dat_i = (k >= int'(cur.delay)) ? cur.rdata : DW'($urandom);
          end
        end else begin
          ack = 1'b0; err = 1'b0; dat_i = DW'($urandom);
          if (cyc_prev) begin
            if (have_cur) check("cyc_len", len, model_len(cur));
            check("idle_adr", adr_o, 32'h0);
            check("idle_dat", dat_o, 16'h0);
            check("idle_we", we_o, 1'b0);
            gap = 0;
          end
          gap++;
        end
        cyc_prev = cyc_o;
      end
    end
  end

  // Response consumer: pops the scoreboard on each handshake and checks stability while stalled
  rsp_t pend;
  bit   pend_v = 1'b0;

  initial begin
    rsp_t e;
    bit   r;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_v = 1'b0; rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (pend_v) begin
          check("rsp_stable_dat", rsp_dat, pend.dat);
          check("rsp_stable_sts", rsp_sts, pend.sts);
        end
        r = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        rsp_ready = r;
        if (r) begin
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 1'b1, 1'b0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_dat", rsp_dat, e.dat);
            check("rsp_sts", rsp_sts, e.sts);
          end
          pend_v = 1'b0;
        end else begin
          pend.dat = rsp_dat; pend.sts = rsp_sts; pend_v = 1'b1;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        pend_v = 1'b0;
      end
    end
  end

  // Called at a negedge; offers the command until accepted and records its expected outcome.
  task automatic issue(input cmd_t c);
    cmd_we = c.we; cmd_adr = c.adr; cmd_dat = c.dat; cmd_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (cmd_ready) begin
        bus_q.push_back(c);
        rsp_q.push_back(model_rsp(c));
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("issue_timeout", 1'b1, 1'b0);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (rsp_q.size() == 0 && bus_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic wait_rsp_valid();
    for (int t = 0; t < 60 && !rsp_valid; t++) @(negedge clk);
    check("rsp_valid_wait", rsp_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    int   sel;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc_o, 1'b0);
    check("rst_stb", stb_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_dat", dat_o, 16'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_dat", rsp_dat, 16'h0);
    check("rst_rsp_sts", rsp_sts, 2'b00);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Write acked two cycles after strobe, then a read returning 0xA5C3.
    issue(mk(1'b1, 32'h10, 16'hBEEF, K_ACK, 2, 16'h1234));
    drain();
    issue(mk(1'b0, 32'h03, 16'h7777, K_ACK, 1, 16'hA5C3));
    drain();

    // Timeout followed by a queued command that must still run.
    issue(mk(1'b0, 32'h20, 16'h0, K_NONE, 0, 16'h5555));
    issue(mk(1'b1, 32'h24, 16'hCAFE, K_ACK, 0, 16'h0));
    drain();

    // Simultaneous ack+err with the response consumer stalled for 5 cycles.
    hold_rsp = 1'b1;
    issue(mk(1'b0, 32'h30, 16'h0, K_BOTH, 1, 16'hFFFF));
    wait_rsp_valid();
    issue(mk(1'b1, 32'h34, 16'h4321, K_ACK, 0, 16'h0));
    repeat (5) begin
      @(negedge clk);
      check("held_no_cyc", cyc_o, 1'b0);
      check("held_valid", rsp_valid, 1'b1);
    end
    hold_rsp = 1'b0;
    drain();

    // Fill the queue while a response is pending, so nothing can be popped.
    hold_rsp = 1'b1;
    issue(mk(1'b1, 32'h40, 16'h0101, K_ACK, 0, 16'h0));
    wait_rsp_valid();
    for (int i = 0; i < DEPTH; i++) begin
      issue(mk(1'(i), 32'h50 + 32'(i), 16'(16'h0A00 + i), K_ACK, 5 + i, 16'(16'hB000 + i)));
    end
    repeat (3) begin
      check("full_ready_low", cmd_ready, 1'b0);
      @(negedge clk);
    end
    hold_rsp = 1'b0;
    issue(mk(1'b0, 32'h60, 16'h0, K_ERR, 3, 16'hDEAD));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      c.we = 1'($urandom_range(0, 1));
      c.adr = $urandom;
      c.dat = DW'($urandom);
      sel = $urandom_range(0, 9);
      c.kind = (sel < 6) ? K_ACK : (sel < 8) ? K_ERR : (sel < 9) ? K_BOTH : K_NONE;
      c.delay = 8'($urandom_range(0, 10));
      c.rdata = DW'($urandom);
      issue(c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();

    // Reset while a transaction is on the bus with two more queued.
    issue(mk(1'b0, 32'h70, 16'h0, K_NONE, 0, 16'h0));
    issue(mk(1'b1, 32'h74, 16'h1111, K_ACK, 0, 16'h0));
    issue(mk(1'b1, 32'h78, 16'h2222, K_ACK, 0, 16'h0));
    for (int t = 0; t < 40 && !cyc_o; t++) @(negedge clk);
    check("pre_rst_cyc", cyc_o, 1'b1);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h99; cmd_dat = 16'h9999;
    @(negedge clk);
    check("mid_rst_cyc", cyc_o, 1'b0);
    check("mid_rst_stb", stb_o, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    bus_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_cyc", cyc_o, 1'b0);
      check("post_rst_rsp_valid", rsp_valid, 1'b0);
    end

    issue(mk(1'b0, 32'h80, 16'h0, K_ACK, 0, 16'h6A6A));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: Wishbone data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command queue entries; power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum bus cycles waited for ack/err; at least 1.
REQ-005 SHALL have one clock and synchronous active-high reset: clk_i input 1, the only clock; rst_i input 1, synchronous reset, active-high.
REQ-006 SHALL have the following command ports:
- cmd_valid_i  input  1  command offered
- cmd_ready_o  output 1  queue can accept
- cmd_we_i  input  1  1=write, 0=read
- cmd_adr_i  input  ADDR_WIDTH  target address
- cmd_dat_i  input  DATA_WIDTH  write data
REQ-007 SHALL have the following response ports:
- rsp_valid_o  output 1  response available
- rsp_ready_i  input  1  response consumed
- rsp_dat_o  output  DATA_WIDTH  read data; 0 for writes
- rsp_sts_o  output 2  00=OK, 01=ERR, 10=TIMEOUT
REQ-008 SHALL have the following Wishbone master ports:
- cyc_o, stb_o, we_o  output 1 each
- adr_o  output ADDR_WIDTH
- dat_o  output DATA_WIDTH
- ack_i, err_i  input 1 each
- dat_i  input DATA_WIDTH
REQ-009 SHALL have busy_o output 1: high when the queue is non-empty, state is not IDLE, or rsp_valid_o is high.

Function
REQ-010 SHALL push a command on a clock edge where cmd_valid_i and cmd_ready_o are both high.
REQ-011 SHALL drive cmd_ready_o = !full, registered-count based; a pop in the same cycle SHALL NOT raise ready while full.
REQ-012 SHALL implement the queue as a circular buffer; pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-013 SHALL run an FSM with states IDLE, BUS and RESP.
REQ-014 IDLE: SHALL pop the head command when the queue is non-empty and rsp_valid_o is low; at the next edge, register cyc_o=stb_o=1, we_o, adr_o and dat_o (dat_o = 0 for reads), clear the timeout counter, and enter BUS.
REQ-015 BUS: SHALL sample ack_i/err_i each edge; on ack_i=1, deassert cyc_o/stb_o at that edge, capture dat_i (reads) into rsp_dat_o, set sts=OK, and enter RESP.
REQ-016 BUS: on err_i=1, SHALL end as REQ-015 but with sts=ERR and rsp_dat_o=0; when ack_i and err_i are high together, err SHALL win.
REQ-017 BUS: SHALL increment the timeout counter each edge without ack/err; on the edge where the counter equals TIMEOUT_CYCLES-1, it SHALL drop cyc_o/stb_o, set sts=TIMEOUT and rsp_dat_o=0, and enter RESP.
REQ-018 RESP: SHALL hold rsp_valid_o=1 with stable data and status until rsp_ready_i=1; it SHALL then clear rsp_valid_o at that edge and return to IDLE.
REQ-019 SHALL keep cyc_o and stb_o identical at all times; both SHALL be high only in BUS.
REQ-020 SHALL return adr_o, dat_o and we_o to 0 on the edge leaving BUS; there is no X on any output.
REQ-021 Minimum back-to-back spacing SHALL be: cyc_o low for at least 2 cycles between transactions (RESP + IDLE pop).
REQ-022 Commands SHALL complete strictly in push order, one outstanding at a time.

Reset
REQ-023 With rst_i=1 at an edge, outputs SHALL be: cyc_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_dat_o, rsp_sts_o all 0; cmd_ready_o=1; busy_o=0; FSM=IDLE; queue empty.
REQ-024 Reset mid-BUS SHALL drop cyc_o/stb_o at that edge, discard queued and in-flight commands, and produce no response.
REQ-025 cmd_valid_i SHALL be ignored in any cycle where rst_i=1.

Verification
REQ-026 Write adr=0x10, dat=0xBEEF, slave acks 2 cycles after stb -> cyc high 3 cycles, we_o=1, rsp sts=00, rsp_dat=0.
REQ-027 Read adr=0x03, slave returns 0xA5C3 with ack -> rsp_dat_o=0xA5C3, sts=00; dat_o=0 during cycle.
REQ-028 Push 5 commands with FIFO_DEPTH=4 and the bus stalled -> cmd_ready_o low after 4th accepted until first pop; all 5 complete in order.
REQ-029 Slave never acks, TIMEOUT_CYCLES=8 -> cyc_o high exactly 8 cycles, sts=10; next queued command proceeds.
REQ-030 ack_i and err_i high together -> sts=01; rsp_ready_i held low 5 cycles -> response stable, no new bus cycle starts.
REQ-031 rst_i pulsed while cyc_o high with 2 queued commands -> cyc_o low next edge, busy_o=0, no rsp_valid_o.
